rpsc_interlock_conditioner: RTL and testbench

- Input stage directly upstream of the card-2 interlock logic. Conditions raw field interlock contacts (card position, emergency, door/PAMP, DC PS, HV connector, PS fault, ...) before they reach the alarm/permission combinational logic.
- Per channel: 2-FF synchroniser, then a stable-time debounce, then an optional fault latch.
- Holds latched faults until an operator acknowledge and records the first fault for diagnostics.
- Runs on the same 1.28 us clock as the downstream 2 s / 4 s timers.

---
 rtl/rpsc_pkg.sv | 17 +
 rtl/rpsc_interlock_conditioner_if.sv | 37 +++
 rtl/rpsc_debounce.sv | 56 +++++
 rtl/rpsc_interlock_conditioner.sv | 127 ++++++++++++
 tb/tb_rpsc_interlock_conditioner.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rpsc_pkg.sv
// Shared definitions for the RPSC interlock conditioner.
//   CLK_PERIOD_NS  : system clock period (1.28 us), shared with the 2 s / 4 s timers
//   DEBOUNCE_10MS  : stable cycles that make up 10 ms at that clock
//   rpsc_ilk_state_t : global interlock state (NORMAL / TRIPPED)
//   id_width()     : width of a channel index, never less than 1 bit
package rpsc_pkg;

   localparam int CLK_PERIOD_NS = 1280;
   localparam int DEBOUNCE_10MS = 7813;

   typedef enum logic {ST_NORMAL, ST_TRIPPED} rpsc_ilk_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rpsc_interlock_conditioner_if.sv
// Signal bundle between the field-contact side and the interlock conditioner.
//   raw_in, latch_mask, ack        : driven by the environment (master)
//   fault_out, any_fault, tripped,
//   first_fault_id/valid, trip_count,
//   state                          : driven by the conditioner (slave)
// There is no valid/ready handshake here: raw_in is asynchronous level
// data, latch_mask is quasi-static and ack is a synchronous pulse sampled
// on every clock edge (a held ack acts as one pulse per edge).
interface rpsc_interlock_conditioner_if #(parameter int N_CH = 8);
   import rpsc_pkg::*;

   localparam int ID_W = id_width(N_CH);

   logic [N_CH-1:0] raw_in;
   logic [N_CH-1:0] latch_mask;
   logic            ack;
   logic [N_CH-1:0] fault_out;
   logic            any_fault;
   logic            tripped;
   logic [ID_W-1:0] first_fault_id;
   logic            first_fault_valid;
   logic [15:0]     trip_count;
   rpsc_ilk_state_t state;

   modport master (
      output raw_in, latch_mask, ack,
      input  fault_out, any_fault, tripped, first_fault_id,
             first_fault_valid, trip_count, state
   );

   modport slave (
      input  raw_in, latch_mask, ack,
      output fault_out, any_fault, tripped, first_fault_id,
             first_fault_valid, trip_count, state
   );

endinterface

// File: rtl/rpsc_debounce.sv
// One interlock channel: 2-flop synchroniser followed by a stable-time
// debounce. The level is accepted only after sync_q has differed from the
// debounced value for DEBOUNCE_CYCLES consecutive edges.
//   clk, reset : clock, asynchronous active-high reset
//   raw        : asynchronous contact input (1 = fault)
//   deb        : debounced level (registered)
//   deb_nxt    : value deb takes on the coming edge, so the top can react
//                on the same edge the level is accepted
module rpsc_debounce
   import rpsc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int CNT_W           = 13
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic deb,
   output logic deb_nxt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             sync_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Any sample equal to deb restarts the count, so glitches are rejected.
   always_comb begin
      deb_nxt = deb;
      cnt_nxt = '0;
      if (sync_q != deb) begin
         if (cnt == LAST) begin
            deb_nxt = sync_q;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         deb    <= 1'b0;
         cnt    <= '0;
      end else begin
         meta   <= raw;
         sync_q <= meta;
         deb    <= deb_nxt;
         cnt    <= cnt_nxt;
      end
   end

endmodule

// File: rtl/rpsc_interlock_conditioner.sv
// Input conditioner in front of the card-2 interlock logic. Each channel is
// synchronised and debounced, optionally latched until an operator ack, and
// a global NORMAL/TRIPPED state records the first channel to fault.
//   clk, reset : 1.28 us clock, asynchronous active-high reset
//   bus        : rpsc_interlock_conditioner_if.slave (inputs raw_in,
//                latch_mask, ack; outputs fault_out, any_fault, tripped,
//                first_fault_id, first_fault_valid, trip_count, state)
// Build option: define RPSC_TRIP_COUNT_EN to build the saturating 16-bit
// trip counter; otherwise trip_count is tied to zero.
module rpsc_interlock_conditioner
   import rpsc_pkg::*;
#(
   parameter int N_CH            = 8,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int CNT_W           = 13
) (
   input logic                          clk,
   input logic                          reset,
   rpsc_interlock_conditioner_if.slave  bus
);

   localparam int ID_W = id_width(N_CH);

   logic [N_CH-1:0] deb;
   logic [N_CH-1:0] deb_nxt;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] lat;
   logic [N_CH-1:0] lat_nxt;
   logic [N_CH-1:0] fault_nxt;
   logic [N_CH-1:0] fault;

   rpsc_ilk_state_t state;
   rpsc_ilk_state_t state_nxt;
   logic [ID_W-1:0] ff_id;
   logic [ID_W-1:0] ff_id_nxt;
   logic            ff_valid;
   logic            ff_valid_nxt;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      rpsc_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .raw     (bus.raw_in[i]),
         .deb     (deb[i]),
         .deb_nxt (deb_nxt[i])
      );
   end

   assign rise = deb_nxt & ~deb;

   // Set wins over ack: an active masked channel re-latches on the same edge.
   assign lat_nxt   = (deb & bus.latch_mask) | (lat & ~({N_CH{bus.ack}} & ~deb));
   // Leaving TRIPPED looks at the fault vector after this edge, so an ack that
   // clears the last latch also returns to NORMAL on that same edge.
   assign fault_nxt = deb_nxt | (lat_nxt & bus.latch_mask);
   assign fault     = deb | (lat & bus.latch_mask);

   always_comb begin
      state_nxt    = state;
      ff_id_nxt    = ff_id;
      ff_valid_nxt = ff_valid;
      case (state)
         ST_NORMAL: begin
            if (|rise) begin
               state_nxt    = ST_TRIPPED;
               ff_valid_nxt = 1'b1;
               // Descending scan so the lowest rising index is the one kept.
               for (int i = N_CH - 1; i >= 0; i--) begin
                  if (rise[i]) ff_id_nxt = ID_W'(i);
               end
            end
         end
         ST_TRIPPED: begin
            if (fault_nxt == '0) begin
               state_nxt    = ST_NORMAL;
               ff_valid_nxt = 1'b0;
               ff_id_nxt    = '0;
            end
         end
         default: state_nxt = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat      <= '0;
         state    <= ST_NORMAL;
         ff_id    <= '0;
         ff_valid <= 1'b0;
      end else begin
         lat      <= lat_nxt;
         state    <= state_nxt;
         ff_id    <= ff_id_nxt;
         ff_valid <= ff_valid_nxt;
      end
   end

`ifdef RPSC_TRIP_COUNT_EN
   logic [15:0] trip_cnt;
   logic        trip_evt;

   assign trip_evt = (state == ST_NORMAL) && (|rise);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trip_cnt <= 16'd0;
      end else if (trip_evt && (trip_cnt != 16'hFFFF)) begin
         trip_cnt <= trip_cnt + 16'd1;
      end
   end

   assign bus.trip_count = trip_cnt;
`else
   assign bus.trip_count = 16'd0;
`endif

   assign bus.fault_out         = fault;
   assign bus.any_fault         = |fault;
   assign bus.tripped           = (state == ST_TRIPPED);
   assign bus.first_fault_id    = ff_id;
   assign bus.first_fault_valid = ff_valid;
   assign bus.state             = state;

endmodule

// File: tb/tb_rpsc_interlock_conditioner.sv
// Bench for rpsc_interlock_conditioner with a short debounce (4 cycles).
// Directed table of test-plan steps, hand sequences for mask drop,
// set-versus-ack and asynchronous reset, then random contacts checked
// against a sample-history reference model.
module tb_rpsc_interlock_conditioner;
   import rpsc_pkg::*;

   localparam int N = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rpsc_interlock_conditioner_if #(.N_CH(N)) bus();

   rpsc_interlock_conditioner #(
      .N_CH            (N),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_tc(input int tc);
`ifdef RPSC_TRIP_COUNT_EN
      return tc;
`else
      return 0;
`endif
   endfunction

   // ---------------- reference model ----------------
   // m_hist[c][k] is the raw value sampled k edges ago (k = 0 is this edge).
   // The synchronised sample seen on an edge is the raw value from two edges
   // earlier; a level is accepted once D such samples in a row differ from
   // the accepted level.
   bit         m_hist [N][D+2];
   logic [N-1:0] m_deb;
   logic [N-1:0] m_lat;
   bit         m_tripped;
   int         m_id;
   bit         m_valid;
   int         m_tc;

   task automatic model_reset();
      for (int c = 0; c < N; c++)
         for (int k = 0; k < D + 2; k++) m_hist[c][k] = 1'b0;
      m_deb = '0; m_lat = '0; m_tripped = 0; m_id = 0; m_valid = 0; m_tc = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] mask, input logic ack);
      logic [N-1:0] new_deb, new_lat, rising, after;
      bit all_diff;
      for (int c = 0; c < N; c++) begin
         for (int k = D + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
         m_hist[c][0] = raw[c];
         all_diff = 1;
         for (int k = 2; k < D + 2; k++)
            if (m_hist[c][k] == m_deb[c]) all_diff = 0;
         new_deb[c] = all_diff ? ~m_deb[c] : m_deb[c];
         if (m_deb[c] && mask[c])  new_lat[c] = 1'b1;
         else if (ack && !m_deb[c]) new_lat[c] = 1'b0;
         else                       new_lat[c] = m_lat[c];
      end
      rising = new_deb & ~m_deb;
      after  = new_deb | (new_lat & mask);
      if (!m_tripped && rising != 0) begin
         m_tripped = 1;
         m_valid   = 1;
         for (int c = N - 1; c >= 0; c--) if (rising[c]) m_id = c;
         if (m_tc < 65535) m_tc++;
      end else if (m_tripped && after == 0) begin
         m_tripped = 0;
         m_valid   = 0;
         m_id      = 0;
      end
      m_deb = new_deb;
      m_lat = new_lat;
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      model_edge(bus.raw_in, bus.latch_mask, bus.ack);
      #1;
   endtask

   task automatic check_all_vs_model(input string tag);
      logic [N-1:0] ef;
      ef = m_deb | (m_lat & bus.latch_mask);
      check({tag, "_fault"},   bus.fault_out, ef);
      check({tag, "_any"},     bus.any_fault, |ef);
      check({tag, "_tripped"}, bus.tripped, m_tripped);
      check({tag, "_id"},      bus.first_fault_id, m_id);
      check({tag, "_valid"},   bus.first_fault_valid, m_valid);
      check({tag, "_tc"},      bus.trip_count, exp_tc(m_tc));
   endtask

   typedef struct {
      logic [7:0] raw;
      logic [7:0] mask;
      logic       ack;
      int         cycles;
      logic [7:0] fault;
      logic       tripped;
      logic [2:0] id;
      logic       valid;
      int         tc;
   } vec_t;

   vec_t vecs [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{8'h00, 8'h00, 1'b0, 20, 8'h00, 1'b0, 3'd0, 1'b0, 0};
      vecs[1]  = '{8'h04, 8'h00, 1'b0,  3, 8'h00, 1'b0, 3'd0, 1'b0, 0};
      vecs[2]  = '{8'h00, 8'h00, 1'b0,  8, 8'h00, 1'b0, 3'd0, 1'b0, 0};
      vecs[3]  = '{8'h04, 8'h04, 1'b0,  5, 8'h00, 1'b0, 3'd0, 1'b0, 0};
      vecs[4]  = '{8'h04, 8'h04, 1'b0,  1, 8'h04, 1'b1, 3'd2, 1'b1, 1};
      vecs[5]  = '{8'h00, 8'h04, 1'b0, 10, 8'h04, 1'b1, 3'd2, 1'b1, 1};
      vecs[6]  = '{8'h00, 8'h04, 1'b1,  1, 8'h00, 1'b0, 3'd0, 1'b0, 1};
      vecs[7]  = '{8'h28, 8'h28, 1'b0,  6, 8'h28, 1'b1, 3'd3, 1'b1, 2};
      vecs[8]  = '{8'h08, 8'h28, 1'b0,  6, 8'h28, 1'b1, 3'd3, 1'b1, 2};
      vecs[9]  = '{8'h08, 8'h28, 1'b1,  1, 8'h08, 1'b1, 3'd3, 1'b1, 2};
      vecs[10] = '{8'h00, 8'h28, 1'b0,  6, 8'h08, 1'b1, 3'd3, 1'b1, 2};
      vecs[11] = '{8'h00, 8'h28, 1'b1,  1, 8'h00, 1'b0, 3'd0, 1'b0, 2};
      vecs[12] = '{8'h01, 8'h00, 1'b0,  5, 8'h00, 1'b0, 3'd0, 1'b0, 2};
      vecs[13] = '{8'h01, 8'h00, 1'b0,  1, 8'h01, 1'b1, 3'd0, 1'b1, 3};
      vecs[14] = '{8'h00, 8'h00, 1'b0,  5, 8'h01, 1'b1, 3'd0, 1'b1, 3};
      vecs[15] = '{8'h00, 8'h00, 1'b0,  1, 8'h00, 1'b0, 3'd0, 1'b0, 3};

      // ---- reset ----
      reset = 1'b1;
      bus.raw_in = '0; bus.latch_mask = '0; bus.ack = 1'b0;
      model_reset();
      #2;
      check("reset_fault", bus.fault_out, 8'h00);
      check("reset_tripped", bus.tripped, 1'b0);
      check("reset_valid", bus.first_fault_valid, 1'b0);
      check("reset_tc", bus.trip_count, 16'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // ---- directed table ----
      for (int v = 0; v < 16; v++) begin
         bus.raw_in = vecs[v].raw; bus.latch_mask = vecs[v].mask; bus.ack = vecs[v].ack;
         repeat (vecs[v].cycles) step();
         check($sformatf("vec%0d_fault", v),   bus.fault_out, vecs[v].fault);
         check($sformatf("vec%0d_any", v),     bus.any_fault, |vecs[v].fault);
         check($sformatf("vec%0d_tripped", v), bus.tripped, vecs[v].tripped);
         check($sformatf("vec%0d_id", v),      bus.first_fault_id, vecs[v].id);
         check($sformatf("vec%0d_valid", v),   bus.first_fault_valid, vecs[v].valid);
         check($sformatf("vec%0d_tc", v),      bus.trip_count, exp_tc(vecs[v].tc));
      end
      bus.ack = 1'b0;

      // ---- clearing latch_mask drops a latched fault without a clock edge ----
      bus.latch_mask = 8'h02; bus.raw_in = 8'h02;
      repeat (6) step();
      check("mask_set_fault", bus.fault_out, 8'h02);
      check("mask_set_id", bus.first_fault_id, 3'd1);
      bus.raw_in = 8'h00;
      repeat (6) step();
      check("mask_latched", bus.fault_out, 8'h02);
      bus.latch_mask = 8'h00;
      #1;
      check("mask_drop_fault", bus.fault_out, 8'h00);
      check("mask_drop_any", bus.any_fault, 1'b0);
      check("mask_drop_still_tripped", bus.tripped, 1'b1);
      step();
      check("mask_drop_normal", bus.tripped, 1'b0);
      check("mask_drop_valid", bus.first_fault_valid, 1'b0);

      // ---- ack on the same edge as an active deb: deb wins ----
      bus.latch_mask = 8'h02; bus.raw_in = 8'h02;
      repeat (6) step();
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      check("ack_vs_deb_fault", bus.fault_out, 8'h02);
      check("ack_vs_deb_tripped", bus.tripped, 1'b1);
      bus.raw_in = 8'h00;
      repeat (6) step();
      check("pre_reset_latched", bus.fault_out, 8'h02);
      check("pre_reset_tc", bus.trip_count, exp_tc(5));

      // ---- asynchronous reset while TRIPPED with a latched fault ----
      #2 reset = 1'b1;
      #1;
      check("async_rst_fault", bus.fault_out, 8'h00);
      check("async_rst_any", bus.any_fault, 1'b0);
      check("async_rst_tripped", bus.tripped, 1'b0);
      check("async_rst_id", bus.first_fault_id, 3'd0);
      check("async_rst_valid", bus.first_fault_valid, 1'b0);
      check("async_rst_tc", bus.trip_count, 16'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      // Latch mask still set: the latched fault must not reappear.
      repeat (3) step();
      check("post_rst_fault", bus.fault_out, 8'h00);

      // ---- random contacts against the reference model ----
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc % 200 == 0) bus.latch_mask = 8'($urandom_range(0, 255));
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 5) == 0) bus.raw_in[c] = ~bus.raw_in[c];
         bus.ack = ($urandom_range(0, 9) == 0);
         step();
         check_all_vs_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
